// File: rtl/reservoir_plant.sv
// Reservoir plant model: integrates valve inflow against the drain demand into a clamped level,
// and reports it through a 3-bit thermometer sensor bus with per-sensor hysteresis.
module reservoir_plant #(
  parameter int LEVEL_W    = 8,
  parameter int MAX_LEVEL  = 200,
  parameter int INIT_LEVEL = 0,
  parameter int TH1        = 50,
  parameter int TH2        = 100,
  parameter int TH3        = 150,
  parameter int HYST       = 4,
  parameter int RATE_FR    = 3,
  parameter int RATE_DFR   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               fr1,
  input  logic               fr2,
  input  logic               fr3,
  input  logic               dfr,
  input  logic [3:0]         drain,
  input  logic               clr_flags,
  output logic [2:0]         s,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow,
  output logic               dry
);

  localparam int SW = LEVEL_W + 2;

  localparam logic [LEVEL_W-1:0] TH_ON  [3] = '{LEVEL_W'(TH1), LEVEL_W'(TH2), LEVEL_W'(TH3)};
  localparam logic [LEVEL_W-1:0] TH_OFF [3] = '{LEVEL_W'(TH1 - HYST), LEVEL_W'(TH2 - HYST),
                                                LEVEL_W'(TH3 - HYST)};

  typedef enum logic {S_OFF = 1'b0, S_ON = 1'b1} sensor_e;

  sensor_e            sen_q [3];
  sensor_e            sen_d [3];
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               overflow_q, overflow_d;
  logic               dry_q, dry_d;

  logic [1:0]         fr_cnt;
  logic signed [SW-1:0] inflow, net, sum;
  logic               above_max, below_zero;
  logic [LEVEL_W-1:0] next_level;

  // Signed arithmetic two bits wider than the level so no input mix can wrap.
  always_comb begin
    fr_cnt     = {1'b0, fr1} + {1'b0, fr2} + {1'b0, fr3};
    inflow     = $signed(SW'(RATE_FR)) * $signed(SW'(fr_cnt))
               + (dfr ? $signed(SW'(RATE_DFR)) : $signed(SW'(0)));
    net        = inflow - $signed(SW'(drain));
    sum        = $signed(SW'(level_q)) + net;
    above_max  = sum > $signed(SW'(MAX_LEVEL));
    below_zero = sum < $signed(SW'(0));
    if (below_zero)     next_level = '0;
    else if (above_max) next_level = LEVEL_W'(MAX_LEVEL);
    else                next_level = sum[LEVEL_W-1:0];
  end

  // Level, per-sensor hysteresis machines and sticky flags; a set beats a clear on the same edge.
  always_comb begin
    level_d    = level_q;
    overflow_d = overflow_q & ~clr_flags;
    dry_d      = dry_q & ~clr_flags;
    for (int n = 0; n < 3; n++) sen_d[n] = sen_q[n];
    if (run) begin
      level_d = next_level;
      if (above_max)  overflow_d = 1'b1;
      if (below_zero) dry_d      = 1'b1;
      for (int n = 0; n < 3; n++) begin
        case (sen_q[n])
          S_OFF:   if (next_level >= TH_ON[n]) sen_d[n] = S_ON;
          S_ON:    if (next_level <  TH_OFF[n]) sen_d[n] = S_OFF;
          default: sen_d[n] = S_OFF;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q    <= LEVEL_W'(INIT_LEVEL);
      overflow_q <= 1'b0;
      dry_q      <= 1'b0;
      for (int n = 0; n < 3; n++)
        sen_q[n] <= (LEVEL_W'(INIT_LEVEL) >= TH_ON[n]) ? S_ON : S_OFF;
    end else begin
      level_q    <= level_d;
      overflow_q <= overflow_d;
      dry_q      <= dry_d;
      for (int n = 0; n < 3; n++) sen_q[n] <= sen_d[n];
    end
  end

  always_comb begin
    for (int n = 0; n < 3; n++) s[n] = (sen_q[n] == S_ON);
  end

  assign level    = level_q;
  assign overflow = overflow_q;
  assign dry      = dry_q;

endmodule
